lif_neuron: RTL
===============

LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter VW, default 8, membrane/current width in bits (signed).
REQ-002 SHALL have parameter RW, default 4, refractory counter width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1, one timestep strobe; state advances only on cycles with enable=1.
REQ-006 SHALL have port input_current, input, VW, signed synaptic current for the current timestep.
REQ-007 SHALL have port threshold, input, VW, signed firing threshold, sampled on each enable cycle.
REQ-008 SHALL have port decay_shift, input, 3, leak amount; leak = V >>> decay_shift; 0 means full leak.
REQ-009 SHALL have port refractory_period, input, RW, number of enable steps spent refractory after a spike.
REQ-010 SHALL have port spike_out, output, 1, registered one-cycle spike pulse.
REQ-011 SHALL have port membrane_potential, output, VW, signed registered membrane state V.
REQ-012 SHALL have port refractory, output, 1, high while in state REFRACTORY.
REQ-013 SHALL have port spike_count, output, 8, saturating spike count (see Configuration).

Function
REQ-014 SHALL implement a two-state FSM: INTEGRATE, REFRACTORY.
REQ-015 In INTEGRATE on enable, SHALL compute V_next = sat(V - (V >>> decay_shift) + input_current) using arithmetic shift and VW+2-bit intermediate, saturated to [-2^(VW-1), 2^(VW-1)-1].
REQ-016 If V_next >= threshold (signed compare), SHALL set V to 0 and assert spike_out on the next cycle for exactly one cycle.
REQ-017 On spike with refractory_period > 0, SHALL load the counter with refractory_period and enter REFRACTORY; with refractory_period = 0, SHALL remain in INTEGRATE.
REQ-018 If V_next < threshold, SHALL set V to V_next, keep spike_out at 0, and remain in INTEGRATE.
REQ-019 In REFRACTORY on enable, SHALL ignore input_current, hold V at 0, and decrement the counter; on the step where the counter decrements to 0, SHALL return to INTEGRATE.
REQ-020 When enable=0, SHALL hold V, state, and counter, and drive spike_out to 0.
REQ-021 Latency from the enable cycle to spike_out SHALL be exactly one clock.
REQ-022 Back-to-back enables SHALL be supported; with refractory_period=0 and large constant current, SHALL spike on every enable step.
REQ-023 Changes to threshold, decay_shift, or refractory_period SHALL take effect on the next enable, with no retroactive effect on a running refractory count.

Reset
REQ-024 On reset low, SHALL immediately set V=0, spike_out=0, refractory=0, counter=0, state=INTEGRATE, and spike_count=0, regardless of clk.
REQ-025 If reset is asserted mid-refractory or mid-spike-pulse, SHALL abort the operation; the first enable after release SHALL integrate from V=0.

Configuration
REQ-026 With macro LIF_SPIKE_COUNT_EN defined, spike_count SHALL increment on each spike_out pulse and saturate at 255.
REQ-027 Without LIF_SPIKE_COUNT_EN, spike_count SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-028 Package snn_pkg SHALL hold the FSM state enum, the default VW/RW constants, and the saturation min/max constants.
REQ-029 The leak-add-saturate datapath SHALL be one combinational sub-module, lif_membrane_update; the FSM and registers SHALL stay in lif_neuron.

Verification
REQ-030 Reset/hold: reset low mid-refractory; release; enable with input 10, threshold 50 -> V=10, refractory=0, no spike.
REQ-031 Integrate-to-fire: decay_shift=7, threshold 50, input 20 on every enable -> V = 20, 40, then spike_out pulse on the third step, V=0.
REQ-032 Leak: V=64, decay_shift=2, input 0 -> V = 48, 36, 27 on successive enables.
REQ-033 Saturation: V=120, input 100, decay_shift=7, threshold 127 -> V clamps to 127, spike fires; V=-120, input -100, threshold 127 -> V=-128, no spike.
REQ-034 Refractory: refractory_period=3, spike, then input 127 for 3 enables -> V held at 0 and refractory=1 for 3 steps, integration resumes on the 4th step; refractory_period=0 -> spike on every enable.
REQ-035 Counter: with LIF_SPIKE_COUNT_EN defined, 300 spikes -> spike_count=255; without the macro -> spike_count=0.

Source files
------------

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg -- shared definitions for the spiking-neuron blocks.
//   * lif_state_t : LIF neuron FSM state (INTEGRATE / REFRACTORY)
//   * VW_DEFAULT  : default membrane/current width (signed bits)
//   * RW_DEFAULT  : default refractory counter width
//   * SAT_MAX/MIN : membrane saturation bounds at the default width
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int VW_DEFAULT = 8;
    localparam int RW_DEFAULT = 4;

    localparam int SAT_MAX = (2 ** (VW_DEFAULT - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (VW_DEFAULT - 1));

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } lif_state_t;

endpackage

// File: rtl/lif_membrane_update.sv
// ---------------------------------------------------------------------------
// lif_membrane_update -- combinational leak / add / saturate datapath.
//   v_next = sat(v - (v >>> decay_shift) + input_current)
// Ports:
//   v             : current membrane potential (signed, VW)
//   input_current : synaptic current for this timestep (signed, VW)
//   decay_shift   : leak shift amount, 0 = full leak
//   v_next        : saturated next membrane potential (signed, VW)
// ---------------------------------------------------------------------------
module lif_membrane_update #(
    parameter int VW = 8
) (
    input  logic signed [VW-1:0] v,
    input  logic signed [VW-1:0] input_current,
    input  logic        [2:0]    decay_shift,
    output logic signed [VW-1:0] v_next
);

    // Two guard bits cover the full range of v - leak + input_current.
    localparam logic signed [VW+1:0] MAXV = {3'b000, {(VW-1){1'b1}}};
    localparam logic signed [VW+1:0] MINV = {3'b111, {(VW-1){1'b0}}};

    logic signed [VW+1:0] v_ext;
    logic signed [VW+1:0] i_ext;
    logic signed [VW+1:0] leak;
    logic signed [VW+1:0] sum;

    always_comb begin
        v_ext = {{2{v[VW-1]}}, v};
        i_ext = {{2{input_current[VW-1]}}, input_current};
        leak  = v_ext >>> decay_shift;
        sum   = v_ext - leak + i_ext;
        if (sum > MAXV) begin
            v_next = MAXV[VW-1:0];
        end else if (sum < MINV) begin
            v_next = MINV[VW-1:0];
        end else begin
            v_next = sum[VW-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// ---------------------------------------------------------------------------
// lif_neuron -- leaky integrate-and-fire neuron with refractory period.
// Ports:
//   clk                : clock, all state changes on rising edge
//   reset              : asynchronous active-low reset
//   enable             : timestep strobe; state advances only when high
//   input_current      : signed synaptic current (VW)
//   threshold          : signed firing threshold (VW)
//   decay_shift        : leak = V >>> decay_shift (0 = full leak)
//   refractory_period  : enable steps spent refractory after a spike (RW)
//   spike_out          : registered one-cycle spike pulse
//   membrane_potential : registered signed membrane state V
//   refractory         : high while in REFRACTORY
//   spike_count        : saturating spike count (0 unless macro defined)
// Build option:
//   LIF_SPIKE_COUNT_EN : when defined, spike_count counts spikes up to 255.
// ---------------------------------------------------------------------------
module lif_neuron
    import snn_pkg::*;
#(
    parameter int VW = VW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [VW-1:0] input_current,
    input  logic signed [VW-1:0] threshold,
    input  logic        [2:0]    decay_shift,
    input  logic        [RW-1:0] refractory_period,
    output logic                 spike_out,
    output logic signed [VW-1:0] membrane_potential,
    output logic                 refractory,
    output logic        [7:0]    spike_count
);

    lif_state_t           state_q, state_d;
    logic        [RW-1:0] cnt_q, cnt_d;
    logic signed [VW-1:0] v_q, v_d;
    logic signed [VW-1:0] v_next;
    logic                 spike_d;
    logic                 fire;

    lif_membrane_update #(
        .VW(VW)
    ) u_update (
        .v             (v_q),
        .input_current (input_current),
        .decay_shift   (decay_shift),
        .v_next        (v_next)
    );

    assign fire = (v_next >= threshold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INTEGRATE;
            cnt_q     <= '0;
            v_q       <= '0;
            spike_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            v_q       <= v_d;
            spike_out <= spike_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        spike_d = 1'b0;
        if (enable) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (fire) begin
                        v_d     = '0;
                        spike_d = 1'b1;
                        if (refractory_period != '0) begin
                            cnt_d   = refractory_period;
                            state_d = ST_REFRACTORY;
                        end
                    end else begin
                        v_d = v_next;
                    end
                end
                ST_REFRACTORY: begin
                    // The counter was captured at the spike, so later changes
                    // to refractory_period do not affect this period.
                    v_d   = '0;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(RW-1){1'b0}}, 1'b1}) begin
                        state_d = ST_INTEGRATE;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = '0;
                    v_d     = '0;
                end
            endcase
        end
    end

    assign membrane_potential = v_q;
    assign refractory         = (state_q == ST_REFRACTORY);

`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] count_q;

    // Counts at the same edge that raises spike_out, so it tracks the pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (spike_d && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = '0;
`endif

endmodule
